// File: rtl/bist_session_scheduler.sv
// Sequences per-core RTS BIST controllers from one start request and checks MISR signatures.
// Optional per-core WAIT watchdog is compiled in with BIST_TIMEOUT_EN.
module bist_session_scheduler #(
  parameter int unsigned NUM_CUT = 4,
  parameter int unsigned SIG_W   = 16,
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned TO_W    = 12
) (
  input  logic                     clk,
  input  logic                     rstIn,
  input  logic                     start,
  input  logic [NUM_CUT-1:0]       cut_mask,
  input  logic [NUM_CUT-1:0]       cut_done,
  input  logic [NUM_CUT*SIG_W-1:0] cut_sig,
  input  logic [NUM_CUT*SIG_W-1:0] golden_sig,
  output logic [NUM_CUT-1:0]       cut_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_CUT-1:0]       fail_vec,
  output logic [NUM_CUT-1:0]       timeout_vec
);

  localparam int unsigned IDX_W = (NUM_CUT > 1) ? $clog2(NUM_CUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CUT-1:0] mask_q, mask_d;
  logic [NUM_CUT-1:0] cut_rst_q, cut_rst_d;
  logic [NUM_CUT-1:0] fail_q, fail_d;
  logic [NUM_CUT-1:0] to_q, to_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               blank_q, blank_d;
  logic               wd_expired;
  logic               sig_mismatch;

  assign sig_mismatch = (cut_sig[idx_q*SIG_W +: SIG_W] != golden_sig[idx_q*SIG_W +: SIG_W]);

`ifdef BIST_TIMEOUT_EN
  // Watchdog: cleared on launch, counts every WAIT cycle.
  logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == S_LAUNCH) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign wd_expired = (wd_cnt_q == TO_W'(TIMEOUT));
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, TO_W};
  assign wd_expired = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    cut_rst_d = '0;
    fail_d    = fail_q;
    to_d      = to_q;
    done_d    = done_q;
    pass_d    = pass_q;
    blank_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = cut_mask;
          fail_d  = '0;
          to_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_q[idx_q]) begin
          cut_rst_d = NUM_CUT'(1) << idx_q;
          state_d   = S_LAUNCH;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_LAUNCH: begin
        blank_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // First WAIT cycle is blanked so a stale done cannot end the wait.
        if (!blank_q && cut_done[idx_q]) begin
          state_d = S_CHECK;
        end else if (wd_expired) begin
          fail_d[idx_q] = 1'b1;
          to_d[idx_q]   = 1'b1;
          state_d       = S_NEXT;
        end
      end
      S_CHECK: begin
        if (sig_mismatch) begin
          fail_d[idx_q] = 1'b1;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == IDX_W'(NUM_CUT - 1)) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SELECT;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        pass_d  = ~|fail_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      cut_rst_q <= '0;
      fail_q    <= '0;
      to_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      cut_rst_q <= cut_rst_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      blank_q   <= blank_d;
    end
  end

  assign cut_rst     = cut_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_vec    = fail_q;
  assign timeout_vec = to_q;

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Self-checking bench for bist_session_scheduler: directed sessions plus randomized sessions
// against a cycle-budget model derived from per-core launch/wait/check durations.
module tb_bist_session_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned SW  = 16;
  localparam int unsigned TMO = 20;
`ifdef BIST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk;
  logic            rstIn;
  logic            start;
  logic [N-1:0]    cut_mask;
  logic [N-1:0]    cut_done;
  logic [N*SW-1:0] cut_sig;
  logic [N*SW-1:0] golden_sig;
  logic [N-1:0]    cut_rst;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N-1:0]    fail_vec;
  logic [N-1:0]    timeout_vec;

  bist_session_scheduler #(
    .NUM_CUT(N),
    .SIG_W  (SW),
    .TIMEOUT(TMO),
    .TO_W   (12)
  ) dut (
    .clk        (clk),
    .rstIn      (rstIn),
    .start      (start),
    .cut_mask   (cut_mask),
    .cut_done   (cut_done),
    .cut_sig    (cut_sig),
    .golden_sig (golden_sig),
    .cut_rst    (cut_rst),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_vec   (fail_vec),
    .timeout_vec(timeout_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-core stimulus and behavioural core models
  int          delay[N];
  bit          mism[N];
  logic [SW-1:0] gold_a[N];
  logic [SW-1:0] sig_a[N];
  int          since[N];
  bit          launched[N];
  bit          stale[N];

  // Expected session outcome
  int          launch_e[N];
  logic [N-1:0] exp_fail;
  logic [N-1:0] exp_to;
  int          done_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core model: done rises delay cycles after the launch cycle; a done already high at
  // launch lingers through the following cycle, like a controller with a slow reset path.
  task automatic update_cores();
    for (int i = 0; i < N; i++) begin
      if (cut_rst[i]) begin
        stale[i]    = cut_done[i];
        since[i]    = 0;
        launched[i] = 1'b1;
      end else if (launched[i] && since[i] < 1000000) begin
        since[i]++;
      end
      if (launched[i]) begin
        cut_done[i] = (since[i] >= delay[i]) || (since[i] <= 1 && stale[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    update_cores();
  endtask

  task automatic prep_sigs();
    for (int i = 0; i < N; i++) begin
      gold_a[i] = SW'($urandom);
      sig_a[i]  = mism[i] ? (gold_a[i] ^ SW'($urandom_range(1, 65535))) : gold_a[i];
    end
  endtask

  task automatic drive_sigs();
    for (int i = 0; i < N; i++) begin
      cut_sig[i*SW +: SW]    = sig_a[i];
      golden_sig[i*SW +: SW] = gold_a[i];
    end
  endtask

  // Session timeline: enabled core costs wait+4 (or TMO+4 on timeout), disabled core costs 2.
  task automatic compute_model(input logic [N-1:0] mask);
    int acc;
    int n;
    bit to;
    acc      = 0;
    exp_fail = '0;
    exp_to   = '0;
    for (int i = 0; i < N; i++) begin
      launch_e[i] = -1;
      if (mask[i]) begin
        n  = (delay[i] < 2) ? 2 : delay[i];
        to = TO_EN && (n > int'(TMO) + 1);
        launch_e[i] = acc + 1;
        acc += to ? int'(TMO) + 4 : n + 4;
        if (to) begin
          exp_to[i]   = 1'b1;
          exp_fail[i] = 1'b1;
        end else if (mism[i]) begin
          exp_fail[i] = 1'b1;
        end
      end else begin
        acc += 2;
      end
    end
    done_e = acc + 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cut_rst"}, 32'(cut_rst), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_fail_vec"}, 32'(fail_vec), 0);
    check({tag, "_timeout_vec"}, 32'(timeout_vec), 0);
  endtask

  task automatic run_session(input logic [N-1:0] mask, input int abort_core, input bit dbl_start);
    logic [N-1:0] exp_rst;
    int abort_e;
    compute_model(mask);
    drive_sigs();
    abort_e = (abort_core >= 0) ? launch_e[abort_core] + 3 : -1;
    check("idle_busy", 32'(busy), 0);
    cut_mask = mask;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cut_mask = N'($urandom);
    check("start_done_clr", 32'(done), 0);
    check("start_pass_clr", 32'(pass), 0);
    check("start_fail_clr", 32'(fail_vec), 0);
    check("start_to_clr", 32'(timeout_vec), 0);
    for (int e = 0; e <= done_e; e++) begin
      if (e > 0) begin
        if (dbl_start && e == 3) start = 1'b1;
        tick();
        start    = 1'b0;
        cut_mask = N'($urandom);
      end
      exp_rst = '0;
      for (int i = 0; i < N; i++) if (launch_e[i] == e) exp_rst[i] = 1'b1;
      check("cut_rst", 32'(cut_rst), 32'(exp_rst));
      check("busy", 32'(busy), 32'(e < done_e));
      check("done", 32'(done), 32'(e == done_e));
      if (e == abort_e) begin
        #2;
        rstIn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
        rstIn = 1'b1;
        tick();
        check_all_zero("post_rst");
        return;
      end
    end
    check("pass", 32'(pass), 32'(exp_fail == '0));
    check("fail_vec", 32'(fail_vec), 32'(exp_fail));
    check("timeout_vec", 32'(timeout_vec), 32'(exp_to));
    repeat (2) begin
      tick();
      check("idle_busy_after", 32'(busy), 0);
      check("done_sticky", 32'(done), 1);
      check("fail_stable", 32'(fail_vec), 32'(exp_fail));
      check("idle_cut_rst", 32'(cut_rst), 0);
    end
  endtask

  task automatic set_all(input int d, input bit m);
    for (int i = 0; i < N; i++) begin
      delay[i] = d;
      mism[i]  = m;
    end
  endtask

  initial begin
    rstIn      = 1'b0;
    start      = 1'b0;
    cut_mask   = '0;
    cut_done   = '0;
    cut_sig    = '0;
    golden_sig = '0;
    for (int i = 0; i < N; i++) begin
      since[i]    = 0;
      launched[i] = 1'b0;
      stale[i]    = 1'b0;
    end
    set_all(10, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstIn = 1'b1;
    tick();

    // All cores enabled, matching signatures: 4*(10+4)+1 cycles
    set_all(10, 1'b0);
    prep_sigs();
    run_session(4'b1111, -1, 1'b0);

    // Core 2 signature mismatch with cores 1 and 3 disabled
    set_all(10, 1'b0);
    prep_sigs();
    mism[2]   = 1'b1;
    sig_a[2]  = 16'hBEEF;
    gold_a[2] = 16'hBEEE;
    run_session(4'b0101, -1, 1'b0);

    // Empty mask
    run_session(4'b0000, -1, 1'b0);

`ifdef BIST_TIMEOUT_EN
    // Core 1 never completes
    set_all(10, 1'b0);
    delay[1] = 1000000;
    prep_sigs();
    run_session(4'b1111, -1, 1'b0);
`endif

    // Stale done on core 0 and a second start while busy
    set_all(10, 1'b0);
    delay[0]    = 5;
    cut_done[0] = 1'b1;
    prep_sigs();
    run_session(4'b0001, -1, 1'b1);

    // Reset during core 2 WAIT, then a full fresh session
    set_all(10, 1'b0);
    prep_sigs();
    run_session(4'b1111, 2, 1'b0);
    run_session(4'b1111, -1, 1'b0);

    // Randomized sessions
    for (int s = 0; s < 24; s++) begin
      for (int i = 0; i < N; i++) begin
        delay[i] = $urandom_range(1, 25);
        mism[i]  = ($urandom_range(0, 3) == 0);
      end
      prep_sigs();
      run_session(N'($urandom), -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed simulation still running, expected completion");
    $fatal(1, "global time limit reached");
  end

endmodule

// File: doc/bist_session_scheduler.md
# bist_session_scheduler

Top-level BIST session sequencer. It runs up to NUM_CUT per-core RTS BIST controllers one after another, from a single start request. For each enabled core it pulses that controller's reset, waits for its done, and compares the core's final MISR signature against a golden value. It then reports per-core fail bits and an overall pass flag to the boot/test-access logic.

## Interface
- NUM_CUT, 4: number of circuits under test / RTS controllers sequenced (1..16)
- SIG_W, 16: MISR signature width per core
- TIMEOUT, 4095: max WAIT cycles per core before declaring timeout (only with watchdog compiled in)
- TO_W, 12: width of the watchdog counter; must satisfy TIMEOUT < 2^TO_W

- clk  in  1  system clock, all state on rising edge
- rstIn  in  1  asynchronous, active-low reset
- start  in  1  level/pulse request, sampled only in IDLE
- cut_mask  in  NUM_CUT  core enable bits, captured on accepted start
- cut_done  in  NUM_CUT  done outputs of the per-core RTS controllers
- cut_sig  in  NUM_CUT*SIG_W  final MISR signatures, core i at [i*SIG_W +: SIG_W]
- golden_sig  in  NUM_CUT*SIG_W  expected signatures, same packing
- cut_rst  out  NUM_CUT  one-cycle active-high reset/launch pulse to RTS controller i
- busy  out  1  session in progress
- done  out  1  session complete; sticky until next accepted start
- pass  out  1  valid when done: no fail bits set
- fail_vec  out  NUM_CUT  per-core mismatch or timeout
- timeout_vec  out  NUM_CUT  per-core watchdog expiry

## Operation
- States: IDLE, SELECT, LAUNCH, WAIT, CHECK, NEXT, FINISH. Core index idx has width clog2(NUM_CUT) (min 1).
- IDLE
  - If start=1: capture mask_q <= cut_mask, clear fail_vec, timeout_vec, done and pass, set idx=0, go to SELECT.
  - Otherwise stay in IDLE.
- SELECT: if mask_q[idx]=1, go to LAUNCH; otherwise go to NEXT.
- LAUNCH: cut_rst[idx]=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT
  - cut_done[idx] is ignored in the first WAIT cycle (blanking, so a stale done from a previous run cannot complete the wait). It is sampled from the second WAIT cycle on.
  - When done is sampled high, go to CHECK.
- CHECK: if cut_sig slice ≠ golden_sig slice, set fail_vec[idx]; go to NEXT.
- NEXT
  - If idx == NUM_CUT-1, go to FINISH.
  - Otherwise idx <= idx+1 and go to SELECT. idx never wraps.
- FINISH: done <= 1, pass <= ~|fail_vec, go to IDLE.
- busy=1 in every state except IDLE; it is a registered/state-decoded level.
- start while busy is ignored and is not queued.
- cut_mask changes during a session have no effect.
- cut_done bits of non-selected cores are ignored.
- Reset (rstIn=0, any state): state=IDLE, idx=0, mask_q=0, counter=0. All outputs are 0: cut_rst=0, busy=0, done=0, pass=0, fail_vec=0, timeout_vec=0.

## Timing
- The start edge is sampled at clock edge T0; busy=1 from T0+.
- Enabled core: SELECT 1 + LAUNCH 1 + WAIT n (n≥2) + CHECK 1 + NEXT 1 = n+4 cycles.
- Disabled core: SELECT 1 + NEXT 1 = 2 cycles.
- FINISH takes 1 cycle. done/pass rise on the edge leaving FINISH, in the same cycle that busy falls.
- The cut_rst pulse is exactly 1 cycle wide, registered, and glitch-free.
- fail_vec bits update on the edge leaving CHECK (or leaving WAIT on timeout). They are stable while done=1.
- All-zero mask: done=1, pass=1 exactly 2*NUM_CUT+1 cycles after start is accepted.

## Configuration
- BIST_TIMEOUT_EN defined:
  - The TO_W-bit counter increments every WAIT cycle.
  - When the counter == TIMEOUT and cut_done[idx]=0: set fail_vec[idx] and timeout_vec[idx], skip CHECK, go to NEXT.
  - If done and the timeout coincide in the same cycle, done wins and the session goes to CHECK.
- BIST_TIMEOUT_EN undefined:
  - No counter is built; WAIT waits indefinitely.
  - timeout_vec is tied to 0.

## Test plan
- NUM_CUT=4, mask=4'b1111, each model asserts done 10 cycles after cut_rst, all signatures match → cut_rst pulses in order 0,1,2,3; done=1, pass=1, fail_vec=0; session takes 4*(10+4)+1 cycles.
- mask=4'b0101, core 2 signature 16'hBEEF vs golden 16'hBEEE → only cut_rst[0] and cut_rst[2] pulse; fail_vec=4'b0100, pass=0.
- mask=0 → no cut_rst pulse; done=1, pass=1 nine cycles after start.
- BIST_TIMEOUT_EN, TIMEOUT=20, core 1 never asserts done → timeout_vec=4'b0010 and fail_vec[1]=1; core 1 WAIT lasts 21 cycles; cores 2 and 3 still run.
- cut_done[0] held high before start (stale), model completes 5 cycles after launch → CHECK is not entered before the second WAIT cycle; second start pulse during busy is ignored.
- rstIn low for 1 cycle during WAIT of core 2 → all outputs 0 immediately (asynchronous); the next start runs a full fresh session from core 0.
